// File: rtl/csa_word_sequencer_if.sv
// Operand/result bus of the multi-precision add/subtract sequencer.
// The master side requests an operation; the slave side is the sequencer.
interface csa_word_sequencer_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, sub, a, b, cin,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, a, b, cin,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/csa_word_sequencer.sv
// Multi-precision add/subtract sequencer: one shared 8-bit carry-skip adder
// processes the operands a byte per cycle, LSB first, with the carry
// chained through a register.

// 8-bit carry-skip adder built from two 4-bit ripple blocks; a block whose
// operand bits all propagate passes its carry-in straight through.
module csa (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [4:0] lo;
    logic [4:0] hi;
    logic       c4;
    logic       p_lo;
    logic       p_hi;

    // Two ripple nibbles with skip muxes on their carry-outs
    always_comb begin
        p_lo = &(a[3:0] ^ b[3:0]);
        p_hi = &(a[7:4] ^ b[7:4]);
        lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
        c4   = p_lo ? ci : lo[4];
        hi   = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, c4};
        co   = p_hi ? c4 : hi[4];
        s    = {hi[3:0], lo[3:0]};
    end
endmodule

module csa_word_sequencer #(
    parameter int NBYTES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    csa_word_sequencer_if.slave  bus
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [NBYTES-1:0][7:0]   a_q;
    logic [NBYTES-1:0][7:0]   b_q;      // effective B' (already inverted for subtract)
    logic [NBYTES-1:0][7:0]   sum_q;
    logic [IW-1:0]            idx_q;
    logic                     carry_q;
    logic                     cout_q;
    logic                     ovf_q;
    logic [7:0]               csa_s;
    logic                     csa_co;
    logic                     last;

    csa u_csa (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (csa_s),
        .co (csa_co)
    );

    assign last = (idx_q == IW'(NBYTES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept only in IDLE, walk the bytes, one DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ADD;
            ADD:     if (last)      state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand latch, byte-serial datapath and final flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                    end
                end
                ADD: begin
                    sum_q[idx_q] <= csa_s;
                    carry_q      <= csa_co;
                    if (last) begin
                        // current bytes are the MSB bytes here
                        cout_q <= csa_co;
                        ovf_q  <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                                  (csa_s[7] != a_q[NBYTES-1][7]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed and random checks of csa_word_sequencer for 4-byte and 1-byte
// operand widths against an integer-arithmetic reference.
module tb_csa_word_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csa_word_sequencer_if #(.NBYTES(4)) bus4 ();
    csa_word_sequencer_if #(.NBYTES(1)) bus1 ();

    csa_word_sequencer #(.NBYTES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    csa_word_sequencer #(.NBYTES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 4-byte operation from an idle point (#1 after a rising edge)
    task automatic run4(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic c);
        logic [32:0] full;
        logic [31:0] bp;
        logic        eovf;
        bp   = s ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bp} + {32'd0, (s ? 1'b1 : c)};
        eovf = (av[31] == bp[31]) && (full[31] != av[31]);
        bus4.a = av; bus4.b = bv; bus4.sub = s; bus4.cin = c; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.a = ~av; bus4.b = ~bv; bus4.sub = ~s;
        check({tag, ".busy"}, bus4.busy, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check({tag, ".done"}, bus4.done, (k == 4));
        end
        check({tag, ".sum"},  bus4.sum,  full[31:0]);
        check({tag, ".cout"}, bus4.cout, full[32]);
        check({tag, ".ovf"},  bus4.ovf,  eovf);
        @(posedge clk); #1;
        check({tag, ".done_off"}, bus4.done, 1'b0);
        check({tag, ".busy_off"}, bus4.busy, 1'b0);
    endtask

    // Full 1-byte operation from an idle point
    task automatic run1(input string tag, input logic s, input logic [7:0] av,
                        input logic [7:0] bv, input logic c);
        logic [8:0] full;
        logic [7:0] bp;
        logic       eovf;
        bp   = s ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bp} + {8'd0, (s ? 1'b1 : c)};
        eovf = (av[7] == bp[7]) && (full[7] != av[7]);
        bus1.a = av; bus1.b = bv; bus1.sub = s; bus1.cin = c; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.a = ~av; bus1.b = ~bv;
        check({tag, ".busy"}, bus1.busy, 1'b1);
        @(posedge clk); #1;
        check({tag, ".done"}, bus1.done, 1'b1);
        check({tag, ".sum"},  bus1.sum,  full[7:0]);
        check({tag, ".cout"}, bus1.cout, full[8]);
        check({tag, ".ovf"},  bus1.ovf,  eovf);
        @(posedge clk); #1;
        check({tag, ".done_off"}, bus1.done, 1'b0);
        check({tag, ".busy_off"}, bus1.busy, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

        // Reset state, then idle with no start
        repeat (3) @(posedge clk);
        #1;
        check("rst.sum",  bus4.sum,  32'h0);
        check("rst.cout", bus4.cout, 1'b0);
        check("rst.ovf",  bus4.ovf,  1'b0);
        check("rst.busy", bus4.busy, 1'b0);
        check("rst.done", bus4.done, 1'b0);
        check("rst.busy1", bus1.busy, 1'b0);
        rst_n = 1'b1;
        bus4.a = 32'h12345678; bus4.b = 32'h9ABCDEF0;
        repeat (3) @(posedge clk);
        #1;
        check("idle.busy", bus4.busy, 1'b0);
        check("idle.done", bus4.done, 1'b0);
        check("idle.sum",  bus4.sum,  32'h0);

        // Directed 4-byte vectors
        run4("add_a6_f5", 1'b0, 32'h000000A6, 32'h000000F5, 1'b0);
        check("add_a6_f5.exp", bus4.sum, 32'h0000019B);
        run4("ripple",    1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        check("ripple.exp_sum",  bus4.sum,  32'h00000000);
        check("ripple.exp_cout", bus4.cout, 1'b1);
        run4("sovf",      1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        check("sovf.exp_sum", bus4.sum, 32'h80000000);
        check("sovf.exp_ovf", bus4.ovf, 1'b1);
        run4("sub_5_7",   1'b1, 32'h00000005, 32'h00000007, 1'b1);
        check("sub_5_7.exp_sum",  bus4.sum,  32'hFFFFFFFE);
        check("sub_5_7.exp_cout", bus4.cout, 1'b0);
        run4("sub_ovf",   1'b1, 32'h80000000, 32'h00000001, 1'b0);
        check("sub_ovf.exp_sum",  bus4.sum,  32'h7FFFFFFF);
        check("sub_ovf.exp_cout", bus4.cout, 1'b1);
        check("sub_ovf.exp_ovf",  bus4.ovf,  1'b1);

        // Start pulses during ADD and DONE must be ignored
        bus4.a = 32'h11111111; bus4.b = 32'h22222222; bus4.sub = 1'b0; bus4.cin = 1'b0;
        bus4.start = 1'b1;
        @(posedge clk); #1;                                  // E0
        bus4.start = 1'b0; bus4.a = 32'hDEADBEEF; bus4.b = 32'h0BADF00D; bus4.sub = 1'b1;
        @(posedge clk); #1;                                  // E1
        bus4.start = 1'b1;
        @(posedge clk); #1;                                  // E2
        bus4.start = 1'b0;
        @(posedge clk); #1;                                  // E3
        @(posedge clk); #1;                                  // E4
        check("ign.done", bus4.done, 1'b1);
        bus4.start = 1'b1;
        @(posedge clk); #1;                                  // E5
        bus4.start = 1'b0;
        check("ign.busy_e5", bus4.busy, 1'b0);
        check("ign.sum",     bus4.sum,  32'h33333333);
        check("ign.cout",    bus4.cout, 1'b0);
        @(posedge clk); #1;
        check("ign.busy_e6", bus4.busy, 1'b0);

        // Start held high: accepts 6 cycles apart, one-cycle done each time
        bus4.a = 32'h01020304; bus4.b = 32'h10203040; bus4.sub = 1'b0; bus4.cin = 1'b0;
        bus4.start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold.done_e%0d", k), bus4.done, (k == 4 || k == 10));
            check($sformatf("hold.busy_e%0d", k), bus4.busy, (k != 5));
        end
        bus4.start = 1'b0;
        check("hold.sum", bus4.sum, 32'h11223344);
        @(posedge clk); #1;
        check("hold.busy_end", bus4.busy, 1'b0);

        // Asynchronous reset during the second ADD cycle
        bus4.a = 32'h01010101; bus4.b = 32'h01010101; bus4.start = 1'b1;
        @(posedge clk); #1;                                  // E0
        bus4.start = 1'b0;
        @(posedge clk); #2;                                  // E1 + 2
        rst_n = 1'b0;
        #1;
        check("mid_rst.sum",  bus4.sum,  32'h0);
        check("mid_rst.busy", bus4.busy, 1'b0);
        check("mid_rst.done", bus4.done, 1'b0);
        check("mid_rst.cout", bus4.cout, 1'b0);
        check("mid_rst.ovf",  bus4.ovf,  1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst.idle", bus4.busy, 1'b0);
        run4("post_rst", 1'b0, 32'h89ABCDEF, 32'h76543210, 1'b1);
        check("post_rst.exp_sum",  bus4.sum,  32'h00000000);
        check("post_rst.exp_cout", bus4.cout, 1'b1);

        // Directed 1-byte vectors
        run1("b1_add", 1'b0, 8'hA6, 8'hF5, 1'b0);
        check("b1_add.exp_sum", bus1.sum, 8'h9B);
        check("b1_add.exp_cout", bus1.cout, 1'b1);
        run1("b1_sub", 1'b1, 8'h80, 8'h01, 1'b0);
        check("b1_sub.exp_sum", bus1.sum, 8'h7F);
        check("b1_sub.exp_ovf", bus1.ovf, 1'b1);

        // Random regression on both widths
        for (int n = 0; n < 1000; n++) begin
            run4($sformatf("rnd4_%0d", n), 1'($urandom_range(1)), 32'($urandom),
                 32'($urandom), 1'($urandom_range(1)));
        end
        for (int n = 0; n < 1000; n++) begin
            run1($sformatf("rnd1_%0d", n), 1'($urandom_range(1)), 8'($urandom_range(255)),
                 8'($urandom_range(255)), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
